interconn_arbiter: RTL and testbench

INTERCONN_ARBITER -- requirements
Module: interconn_arbiter

---
 rtl/interconn_arbiter.sv | 150 +++++++++++++++
 tb/tb_interconn_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interconn_arbiter.sv
// rtl/interconn_arbiter.sv - per-destination round-robin burst arbiter for the MVU interconnect
// Each destination locks to one requester for a whole burst; send_* follow an accepted beat by one cycle.
module interconn_arbiter #(
    parameter int N     = 8,
    parameter int W     = 64,
    parameter int BADDR = 15,
    parameter int DW    = 3
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic [N-1:0]       req_valid,
    input  logic [N-1:0]       req_last,
    input  logic [N*DW-1:0]    req_dest,
    input  logic [N*BADDR-1:0] req_addr,
    input  logic [N*W-1:0]     req_word,
    output logic [N-1:0]       req_ready,
    output logic [N*N-1:0]     send_to,
    output logic [N-1:0]       send_en,
    output logic [N*BADDR-1:0] send_addr,
    output logic [N*W-1:0]     send_word,
    output logic [N-1:0]       dest_busy
);

    logic [N-1:0]  r_locked;
    logic [DW-1:0] r_owner [N];
    logic [DW-1:0] r_rr    [N];

    logic [N-1:0]  w_locked_nxt;
    logic [DW-1:0] w_owner_nxt [N];
    logic [DW-1:0] w_rr_nxt    [N];
    logic [DW-1:0] w_dest      [N];
    logic [N-1:0]  w_is_owner;
    logic [N-1:0]  w_req_to    [N];
    logic [N-1:0]  w_found;
    logic [DW-1:0] w_pick      [N];
    logic [N-1:0]  w_accept;

    always_comb begin
        for (int r = 0; r < N; r++) begin
            w_dest[r] = req_dest[r*DW +: DW];
        end
    end

    // A requester already holding a lock may not compete for any other destination.
    always_comb begin
        w_is_owner = '0;
        for (int d = 0; d < N; d++) begin
            for (int r = 0; r < N; r++) begin
                if (r_locked[d] && (r_owner[d] == DW'(r))) begin
                    w_is_owner[r] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int d = 0; d < N; d++) begin
            w_req_to[d] = '0;
            for (int r = 0; r < N; r++) begin
                w_req_to[d][r] = req_valid[r] && (w_dest[r] == DW'(d)) && !w_is_owner[r];
            end
        end
    end

    always_comb begin
        int            idx;
        logic [DW-1:0] w_idx;
        idx   = 0;
        w_idx = '0;
        for (int d = 0; d < N; d++) begin
            w_found[d] = 1'b0;
            w_pick[d]  = '0;
            for (int i = 0; i < N; i++) begin
                idx = int'(r_rr[d]) + i;
                if (idx >= N) begin
                    idx = idx - N;
                end
                w_idx = DW'(idx);
                if (!w_found[d] && w_req_to[d][w_idx]) begin
                    w_found[d] = 1'b1;
                    w_pick[d]  = w_idx;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_locked <= '0;
            for (int d = 0; d < N; d++) begin
                r_owner[d] <= '0;
                r_rr[d]    <= '0;
            end
        end else begin
            r_locked <= w_locked_nxt;
            r_owner  <= w_owner_nxt;
            r_rr     <= w_rr_nxt;
        end
    end

    always_comb begin
        w_locked_nxt = r_locked;
        w_owner_nxt  = r_owner;
        w_rr_nxt     = r_rr;
        for (int d = 0; d < N; d++) begin
            if (r_locked[d]) begin
                if (w_accept[r_owner[d]] && req_last[r_owner[d]]) begin
                    w_locked_nxt[d] = 1'b0;
                    w_rr_nxt[d]     = (r_owner[d] == DW'(N-1)) ? '0 : r_owner[d] + 1'b1;
                end
            end else if (w_found[d]) begin
                w_locked_nxt[d] = 1'b1;
                w_owner_nxt[d]  = w_pick[d];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int d = 0; d < N; d++) begin
            if (r_locked[d] && req_valid[r_owner[d]] && (w_dest[r_owner[d]] == DW'(d))) begin
                req_ready[r_owner[d]] = 1'b1;
            end
        end
    end

    assign w_accept  = req_valid & req_ready;
    assign dest_busy = r_locked;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            send_to   <= '0;
            send_en   <= '0;
            send_addr <= '0;
            send_word <= '0;
        end else begin
            send_en <= w_accept;
            for (int r = 0; r < N; r++) begin
                for (int d = 0; d < N; d++) begin
                    send_to[r*N+d] <= w_accept[r] && (w_dest[r] == DW'(d));
                end
                if (w_accept[r]) begin
                    send_addr[r*BADDR +: BADDR] <= req_addr[r*BADDR +: BADDR];
                    send_word[r*W +: W]         <= req_word[r*W +: W];
                end
            end
        end
    end

endmodule

// File: tb/tb_interconn_arbiter.sv
// tb/tb_interconn_arbiter.sv - randomized scoreboard bench for interconn_arbiter
module tb_interconn_arbiter;
    localparam int N     = 8;
    localparam int W     = 64;
    localparam int BADDR = 15;
    localparam int DW    = 3;
    localparam int N6    = 6;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]       req_valid, req_last, req_ready, send_en, dest_busy;
    logic [N*DW-1:0]    req_dest;
    logic [N*BADDR-1:0] req_addr, send_addr;
    logic [N*W-1:0]     req_word, send_word;
    logic [N*N-1:0]     send_to;

    logic [N6-1:0]       s_valid, s_last, s_ready, s_en, s_busy;
    logic [N6*DW-1:0]    s_dest;
    logic [N6*BADDR-1:0] s_addr, s_saddr;
    logic [N6*W-1:0]     s_word, s_sword;
    logic [N6*N6-1:0]    s_to;

    interconn_arbiter #(.N(N), .W(W), .BADDR(BADDR), .DW(DW)) u_dut (
        .clk(clk), .clr_n(clr_n), .req_valid(req_valid), .req_last(req_last),
        .req_dest(req_dest), .req_addr(req_addr), .req_word(req_word), .req_ready(req_ready),
        .send_to(send_to), .send_en(send_en), .send_addr(send_addr), .send_word(send_word),
        .dest_busy(dest_busy)
    );

    interconn_arbiter #(.N(N6), .W(W), .BADDR(BADDR), .DW(DW)) u_dut6 (
        .clk(clk), .clr_n(clr_n), .req_valid(s_valid), .req_last(s_last),
        .req_dest(s_dest), .req_addr(s_addr), .req_word(s_word), .req_ready(s_ready),
        .send_to(s_to), .send_en(s_en), .send_addr(s_saddr), .send_word(s_sword),
        .dest_busy(s_busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int               dest;
        logic [BADDR-1:0] addr;
        logic [W-1:0]     word;
    } beat_t;

    beat_t exp_q [N][$];

    // Reference model: per-destination lock flag, owner and round-robin start.
    bit m_locked [N];
    int m_owner  [N];
    int m_rr     [N];

    bit b_act [N];
    int b_dest[N];
    int b_len [N];
    int b_left[N];
    int b_gap [N];
    int b_hold[N];
    bit b_rep [N];

    logic [N-1:0] seen_rdy, seen_busy;

    function automatic int dest_of(input int r);
        return int'(req_dest[r*DW +: DW]);
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] rdy;
        rdy = '0;
        for (int d = 0; d < N; d++) begin
            if (m_locked[d] && req_valid[m_owner[d]] && dest_of(m_owner[d]) == d) rdy[m_owner[d]] = 1'b1;
        end
        return rdy;
    endfunction

    function automatic logic [N-1:0] model_busy();
        logic [N-1:0] b;
        for (int d = 0; d < N; d++) b[d] = m_locked[d];
        return b;
    endfunction

    function automatic bit any_active();
        bit a;
        a = 0;
        for (int r = 0; r < N; r++) a = a | b_act[r];
        return a;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < N; d++) begin
            m_locked[d] = 0;
            m_owner[d]  = 0;
            m_rr[d]     = 0;
            exp_q[d].delete();
            b_act[d]  = 0;
            b_left[d] = 0;
            b_hold[d] = 0;
            b_rep[d]  = 0;
        end
    endtask

    task automatic model_step(input logic [N-1:0] rdy);
        bit    owns [N];
        int    o, c;
        bit    got;
        beat_t b;
        for (int r = 0; r < N; r++) owns[r] = 0;
        for (int d = 0; d < N; d++) if (m_locked[d]) owns[m_owner[d]] = 1;
        for (int r = 0; r < N; r++) begin
            if (rdy[r]) begin
                b.dest = dest_of(r);
                b.addr = req_addr[r*BADDR +: BADDR];
                b.word = req_word[r*W +: W];
                exp_q[r].push_back(b);
            end
        end
        for (int d = 0; d < N; d++) begin
            if (m_locked[d]) begin
                o = m_owner[d];
                if (rdy[o] && req_last[o]) begin
                    m_locked[d] = 0;
                    m_rr[d]     = (o + 1) % N;
                end
            end else begin
                got = 0;
                for (int k = 0; k < N; k++) begin
                    c = (m_rr[d] + k) % N;
                    if (!got && req_valid[c] && dest_of(c) == d && !owns[c]) begin
                        got         = 1;
                        m_locked[d] = 1;
                        m_owner[d]  = c;
                    end
                end
            end
        end
    endtask

    task automatic start_burst(input int r, input int dest, input int len, input int gap, input bit rep);
        b_act[r]  = 1;
        b_dest[r] = dest;
        b_len[r]  = len;
        b_left[r] = len;
        b_gap[r]  = gap;
        b_rep[r]  = rep;
    endtask

    task automatic drive_inputs();
        logic v;
        for (int r = 0; r < N; r++) begin
            v = b_act[r] && ($urandom_range(99) >= b_gap[r]);
            if (b_hold[r] > 0) begin
                v = 1'b0;
                b_hold[r]--;
            end
            req_valid[r]                = v;
            req_last[r]                 = (b_left[r] == 1);
            req_dest[r*DW +: DW]        = DW'(b_dest[r]);
            req_addr[r*BADDR +: BADDR]  = BADDR'($urandom);
            req_word[r*W +: W]          = {$urandom, $urandom};
        end
    endtask

    task automatic cycle(output logic [N-1:0] rdy);
        #1;
        rdy       = model_ready();
        seen_rdy  = req_ready;
        seen_busy = dest_busy;
        check("req_ready", req_ready, rdy);
        check("dest_busy", dest_busy, model_busy());
        @(posedge clk);
        model_step(rdy);
        @(negedge clk);
    endtask

    task automatic step_bursts(input logic [N-1:0] rdy);
        for (int r = 0; r < N; r++) begin
            if (b_act[r] && rdy[r]) begin
                b_left[r]--;
                if (b_left[r] == 0) begin
                    if (b_rep[r]) b_left[r] = b_len[r];
                    else b_act[r] = 0;
                end
            end
        end
    endtask

    task automatic run(input int n);
        logic [N-1:0] rdy;
        repeat (n) begin
            drive_inputs();
            cycle(rdy);
            step_bursts(rdy);
        end
    endtask

    beat_t mon_b;
    always @(posedge clk) begin
        #2;
        for (int r = 0; r < N; r++) begin
            if (exp_q[r].size() > 0) begin
                mon_b = exp_q[r].pop_front();
                check("send_en beat", send_en[r], 1);
                check("send_to beat", send_to[r*N +: N], 64'(1) << mon_b.dest);
                check("send_addr beat", send_addr[r*BADDR +: BADDR], mon_b.addr);
                check("send_word beat", send_word[r*W +: W], mon_b.word);
            end else begin
                check("send_en idle", send_en[r], 0);
                check("send_to idle", send_to[r*N +: N], 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] rdy;
        int er[5];
        int gexp[4];
        int ng, first2, n1, guard;
        logic [N-1:0] r37[4];
        req_valid = '0; req_last = '0; req_dest = '0; req_addr = '0; req_word = '0;
        s_valid = '1; s_last = '1; s_addr = '0; s_word = '0;
        for (int i = 0; i < N6; i++) s_dest[i*DW +: DW] = (i % 2 == 1) ? 3'd7 : 3'd6;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst send_en", send_en, 0);
        check("rst send_to", send_to, 0);
        check("rst send_addr", 64'(|send_addr), 0);
        check("rst send_word", 64'(|send_word), 0);
        check("rst dest_busy", dest_busy, 0);
        check("rst req_ready", req_ready, 0);
        @(negedge clk);
        clr_n = 1'b1;

        er = '{0, 1, 1, 1, 0};
        start_burst(2, 5, 3, 0, 0);
        for (int k = 0; k < 5; k++) begin
            drive_inputs(); cycle(rdy); step_bursts(rdy);
            check("r033 ready2", seen_rdy[2], er[k]);
            check("r033 busy5", seen_busy[5], er[k]);
            check("r033 send_en2", send_en[2], er[k]);
            check("r033 send_to21", send_to[21], er[k]);
        end

        gexp = '{0, 3, 6, 0};
        ng = 0;
        start_burst(0, 1, 1, 0, 1); start_burst(3, 1, 1, 0, 1); start_burst(6, 1, 1, 0, 1);
        for (int k = 0; k < 8; k++) begin
            drive_inputs(); cycle(rdy); step_bursts(rdy);
            for (int r = 0; r < N; r++) begin
                if (seen_rdy[r]) begin
                    if (ng < 4) check("r034 grant", r, gexp[ng]);
                    ng++;
                end
            end
        end
        check("r034 grant count", ng, 4);
        for (int r = 0; r < N; r++) begin b_act[r] = 0; b_rep[r] = 0; b_left[r] = 0; end
        run(2);

        start_burst(4, 0, 1, 0, 0); start_burst(7, 2, 1, 0, 0);
        run(2);
        check("r035 busy0", seen_busy[0], 1);
        check("r035 busy2", seen_busy[2], 1);
        check("r035 send_en4", send_en[4], 1);
        check("r035 send_en7", send_en[7], 1);
        run(1);

        start_burst(1, 3, 4, 0, 0); start_burst(2, 3, 1, 0, 0);
        first2 = -1; n1 = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 3) b_hold[1] = 3;
            drive_inputs(); cycle(rdy); step_bursts(rdy);
            if (seen_rdy[1] && first2 < 0) n1++;
            if (seen_rdy[2] && first2 < 0) first2 = k;
        end
        check("r036 first ready2 cycle", first2, 9);
        check("r036 owner beats before", n1, 4);

        start_burst(5, 0, 1, 0, 0); run(3);
        start_burst(1, 0, 4, 0, 0); run(3);
        #2 clr_n = 1'b0;
        #1;
        check("r037 send_en", send_en, 0);
        check("r037 send_to", send_to, 0);
        check("r037 dest_busy", dest_busy, 0);
        check("r037 req_ready", req_ready, 0);
        check("r037 send_addr", 64'(|send_addr), 0);
        check("r037 send_word", 64'(|send_word), 0);
        model_reset();
        req_valid = '0;
        @(negedge clk);
        clr_n = 1'b1;
        start_burst(5, 0, 1, 0, 0); start_burst(6, 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            drive_inputs(); cycle(rdy); step_bursts(rdy);
            r37[k] = seen_rdy;
        end
        check("r037 first grant 5", r37[1][5], 1);
        check("r037 first not 6", r37[1][6], 0);
        check("r037 second grant 6", r37[3][6], 1);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int r = 0; r < N; r++) begin
                if (!b_act[r] && $urandom_range(99) < 30)
                    start_burst(r, $urandom_range(N-1), $urandom_range(1, 4), $urandom_range(0, 40), 0);
            end
            drive_inputs(); cycle(rdy); step_bursts(rdy);
        end
        for (int r = 0; r < N; r++) b_gap[r] = 0;
        guard = 0;
        while (any_active() && guard < 500) begin
            run(1);
            guard++;
        end
        check("drain bound", 64'(guard < 500), 1);
        run(3);
        for (int r = 0; r < N; r++) check("queue empty", exp_q[r].size(), 0);

        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("n6 req_ready", s_ready, 0);
            check("n6 send_en", s_en, 0);
            check("n6 dest_busy", s_busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
